// File: rtl/m_mem_arbiter.sv
// Two-port arbiter sharing one single-port memory between instruction fetch (I)
// and load/store (D): D-priority with a starvation guard for I, owner-tagged reads.
module m_mem_arbiter #(
    parameter int P_MAXD = 4
) (
    input  logic        w_clk,
    input  logic        w_rst_n,
    input  logic        w_ce,
    input  logic        w_ireq,
    input  logic [11:0] w_iaddr,
    output logic        w_ignt,
    output logic        w_irvalid,
    output logic [31:0] w_irdata,
    input  logic        w_dreq,
    input  logic [11:0] w_daddr,
    input  logic        w_dwe,
    input  logic [31:0] w_dwdata,
    output logic        w_dgnt,
    output logic        w_drvalid,
    output logic [31:0] w_drdata,
    output logic [11:0] w_maddr,
    output logic        w_mwe,
    output logic [31:0] w_mdin,
    input  logic [31:0] w_mdout,
    output logic [15:0] w_conflicts
);

    localparam logic [3:0] LP_MAXD = 4'(P_MAXD);

    function automatic logic [15:0] f_sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [3:0]  r_dcnt;
    logic [11:0] r_last_addr;
    logic        r_irvalid_p1;
    logic        r_drvalid_p1;
    logic [15:0] r_conflicts;

    logic        w_run;
    logic        w_iforce;
    logic        w_conflict;
    logic [3:0]  w_dcnt_nxt;

    // Gating by w_rst_n keeps grants (and hence w_mwe) low during reset.
    assign w_run      = w_rst_n & w_ce;
    assign w_iforce   = (r_dcnt == LP_MAXD);
    assign w_conflict = w_ireq & w_dreq & w_ce;

    assign w_ignt = w_run & w_ireq & (~w_dreq | w_iforce);
    assign w_dgnt = w_run & w_dreq & ~(w_ireq & w_iforce);

    assign w_maddr = w_ignt ? w_iaddr : (w_dgnt ? w_daddr : r_last_addr);
    assign w_mwe   = w_dgnt & w_dwe;
    assign w_mdin  = w_dwdata;

    always_comb begin
        w_dcnt_nxt = r_dcnt;
        if (w_ce) begin
            if (w_ignt || !w_ireq) begin
                w_dcnt_nxt = 4'd0;
            end else if (w_dgnt && (r_dcnt < LP_MAXD)) begin
                w_dcnt_nxt = r_dcnt + 4'd1;
            end
        end
    end

    // Stage p1: owner tags for the registered memory read
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_dcnt       <= 4'd0;
            r_last_addr  <= 12'd0;
            r_irvalid_p1 <= 1'b0;
            r_drvalid_p1 <= 1'b0;
            r_conflicts  <= 16'd0;
        end else begin
            r_dcnt       <= w_dcnt_nxt;
            r_irvalid_p1 <= w_ignt;
            r_drvalid_p1 <= w_dgnt & ~w_dwe;
            if (w_ignt || w_dgnt) begin
                r_last_addr <= w_maddr;
            end
            if (w_conflict) begin
                r_conflicts <= f_sat_inc16(r_conflicts);
            end
        end
    end

    assign w_irvalid   = r_irvalid_p1;
    assign w_drvalid   = r_drvalid_p1;
    assign w_irdata    = w_mdout;
    assign w_drdata    = w_mdout;
    assign w_conflicts = r_conflicts;

endmodule

// File: tb/tb_m_mem_arbiter.sv
// Directed testbench for m_mem_arbiter with a behavioural 4K x 32 memory;
// unwritten words read back as 32'hA000_0000 | address.
module tb_m_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        ce;
    logic        ireq;
    logic [11:0] iaddr;
    logic        ignt;
    logic        irvalid;
    logic [31:0] irdata;
    logic        dreq;
    logic [11:0] daddr;
    logic        dwe;
    logic [31:0] dwdata;
    logic        dgnt;
    logic        drvalid;
    logic [31:0] drdata;
    logic [11:0] maddr;
    logic        mwe;
    logic [31:0] mdin;
    logic [31:0] mdout;
    logic [15:0] conflicts;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem [0:4095];
    bit          wr  [0:4095];

    m_mem_arbiter #(.P_MAXD(4)) dut (
        .w_clk(clk), .w_rst_n(rst_n), .w_ce(ce),
        .w_ireq(ireq), .w_iaddr(iaddr), .w_ignt(ignt),
        .w_irvalid(irvalid), .w_irdata(irdata),
        .w_dreq(dreq), .w_daddr(daddr), .w_dwe(dwe), .w_dwdata(dwdata),
        .w_dgnt(dgnt), .w_drvalid(drvalid), .w_drdata(drdata),
        .w_maddr(maddr), .w_mwe(mwe), .w_mdin(mdin), .w_mdout(mdout),
        .w_conflicts(conflicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mwe) begin
            mem[maddr] <= mdin;
            wr[maddr]  <= 1'b1;
        end
        mdout <= wr[maddr] ? mem[maddr] : (32'hA000_0000 | {20'd0, maddr});
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ireq  = 1'b0;
        dreq  = 1'b0;
        dwe   = 1'b0;
        ce    = 1'b1;
        #1;
        cyc();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ce = 1'b1;
        ireq = 1'b1; iaddr = 12'h008;
        dreq = 1'b1; daddr = 12'h010; dwe = 1'b1; dwdata = 32'h0000_0BAD;
        #2;
        n_tests++; if (ignt !== 1'b0 || dgnt !== 1'b0) begin n_fail++; $display("FAIL rst_gnt ignt=%b dgnt=%b required 0/0", ignt, dgnt); end
        n_tests++; if (mwe !== 1'b0) begin n_fail++; $display("FAIL rst_mwe got %b required 0", mwe); end
        cyc();
        n_tests++; if (irvalid !== 1'b0 || drvalid !== 1'b0 || conflicts !== 16'd0) begin
            n_fail++; $display("FAIL rst_regs irv=%b drv=%b conf=%0d required 0/0/0", irvalid, drvalid, conflicts);
        end
        rst_n = 1'b1; dwe = 1'b0;
        #1;
        n_tests++; if (dgnt !== 1'b1 || ignt !== 1'b0) begin n_fail++; $display("FAIL rst_first_gnt ignt=%b dgnt=%b required 0/1", ignt, dgnt); end
        cyc();
        ireq = 1'b0; dreq = 1'b0;
        n_tests++; if (drvalid !== 1'b1 || drdata !== 32'hA000_0010) begin
            n_fail++; $display("FAIL rst_first_load drv=%b data=%h required 1/a0000010", drvalid, drdata);
        end
        n_tests++; if (conflicts !== 16'd1) begin n_fail++; $display("FAIL rst_conf got %0d required 1", conflicts); end
    endtask

    task automatic test_i_only();
        do_reset();
        ireq = 1'b1; iaddr = 12'd0;
        #1;
        n_tests++; if (ignt !== 1'b1 || maddr !== 12'd0) begin n_fail++; $display("FAIL ionly_gnt0 ignt=%b maddr=%h required 1/000", ignt, maddr); end
        for (int k = 1; k <= 3; k++) begin
            cyc();
            n_tests++; if (irvalid !== 1'b1 || irdata !== (32'hA000_0000 | 32'(k - 1))) begin
                n_fail++; $display("FAIL ionly_data%0d irv=%b data=%h required 1/%h", k - 1, irvalid, irdata, 32'hA000_0000 | 32'(k - 1));
            end
            if (k < 3) begin
                iaddr = 12'(k);
                #1;
                n_tests++; if (ignt !== 1'b1 || maddr !== 12'(k)) begin n_fail++; $display("FAIL ionly_gnt%0d ignt=%b maddr=%h", k, ignt, maddr); end
            end else begin
                ireq = 1'b0;
                #1;
                n_tests++; if (ignt !== 1'b0 || maddr !== 12'd2) begin n_fail++; $display("FAIL ionly_idle ignt=%b maddr=%h required 0/002", ignt, maddr); end
            end
        end
        cyc();
        n_tests++; if (irvalid !== 1'b0) begin n_fail++; $display("FAIL ionly_tail irv=%b required 0", irvalid); end
    endtask

    task automatic test_store_load();
        do_reset();
        dreq = 1'b1; dwe = 1'b1; daddr = 12'h100; dwdata = 32'hDEAD_BEEF;
        #1;
        n_tests++; if (dgnt !== 1'b1 || mwe !== 1'b1 || maddr !== 12'h100 || mdin !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL st_gnt dgnt=%b mwe=%b maddr=%h mdin=%h required 1/1/100/deadbeef", dgnt, mwe, maddr, mdin);
        end
        cyc();
        n_tests++; if (drvalid !== 1'b0) begin n_fail++; $display("FAIL st_no_rvalid drv=%b required 0", drvalid); end
        dwe = 1'b0; dwdata = 32'h0;
        #1;
        n_tests++; if (dgnt !== 1'b1 || mwe !== 1'b0) begin n_fail++; $display("FAIL ld_gnt dgnt=%b mwe=%b required 1/0", dgnt, mwe); end
        cyc();
        n_tests++; if (drvalid !== 1'b1 || drdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL ld_data drv=%b data=%h required 1/deadbeef", drvalid, drdata);
        end
        dreq = 1'b0;
        #1;
        n_tests++; if (dgnt !== 1'b0 || mwe !== 1'b0 || maddr !== 12'h100) begin
            n_fail++; $display("FAIL ld_idle dgnt=%b mwe=%b maddr=%h required 0/0/100", dgnt, mwe, maddr);
        end
        cyc();
        n_tests++; if (drvalid !== 1'b0) begin n_fail++; $display("FAIL ld_tail drv=%b required 0", drvalid); end
    endtask

    task automatic test_starvation();
        int prev;
        int exp;
        do_reset();
        ireq = 1'b1; iaddr = 12'h020;
        dreq = 1'b1; daddr = 12'h030; dwe = 1'b0;
        prev = 0;
        for (int k = 0; k < 10; k++) begin
            n_tests++; if (irvalid !== (prev == 1) || drvalid !== (prev == 2)) begin
                n_fail++; $display("FAIL starv_rvalid c%0d irv=%b drv=%b required %0d/%0d", k, irvalid, drvalid, prev == 1, prev == 2);
            end
            n_tests++; if (conflicts !== 16'(k)) begin n_fail++; $display("FAIL starv_conf c%0d got %0d required %0d", k, conflicts, k); end
            #1;
            exp = (k % 5 == 4) ? 1 : 2;
            n_tests++; if (ignt !== (exp == 1) || dgnt !== (exp == 2)) begin
                n_fail++; $display("FAIL starv_gnt c%0d ignt=%b dgnt=%b required %0d/%0d", k, ignt, dgnt, exp == 1, exp == 2);
            end
            prev = exp;
            cyc();
        end
        ireq = 1'b0; dreq = 1'b0;
    endtask

    task automatic test_ce_gating();
        int ce_tab  [14] = '{1, 1, 1, 1, 1, 0, 0, 0, 1, 1, 0, 1, 1, 1};
        int exp_tab [14] = '{2, 2, 2, 2, 1, 0, 0, 0, 2, 2, 0, 2, 2, 1};
        int prev;
        int nconf;
        logic [11:0] last;
        logic [11:0] exp_addr;
        do_reset();
        ireq = 1'b1; iaddr = 12'h020;
        dreq = 1'b1; daddr = 12'h030; dwe = 1'b0;
        prev = 0; nconf = 0; last = 12'h000;
        for (int k = 0; k < 14; k++) begin
            n_tests++; if (irvalid !== (prev == 1) || drvalid !== (prev == 2)) begin
                n_fail++; $display("FAIL ce_rvalid c%0d irv=%b drv=%b required %0d/%0d", k, irvalid, drvalid, prev == 1, prev == 2);
            end
            if (prev == 1) begin
                n_tests++; if (irdata !== 32'hA000_0020) begin n_fail++; $display("FAIL ce_idata c%0d got %h required a0000020", k, irdata); end
            end
            n_tests++; if (conflicts !== 16'(nconf)) begin n_fail++; $display("FAIL ce_conf c%0d got %0d required %0d", k, conflicts, nconf); end
            ce = ce_tab[k][0];
            #1;
            exp_addr = (exp_tab[k] == 1) ? 12'h020 : ((exp_tab[k] == 2) ? 12'h030 : last);
            n_tests++; if (ignt !== (exp_tab[k] == 1) || dgnt !== (exp_tab[k] == 2) || maddr !== exp_addr) begin
                n_fail++; $display("FAIL ce_gnt c%0d ignt=%b dgnt=%b maddr=%h required %0d/%0d/%h",
                                   k, ignt, dgnt, maddr, exp_tab[k] == 1, exp_tab[k] == 2, exp_addr);
            end
            prev = exp_tab[k];
            last = exp_addr;
            if (ce_tab[k] == 1) nconf++;
            cyc();
        end
        ireq = 1'b0; dreq = 1'b0; ce = 1'b1;
    endtask

    task automatic test_mid_reset();
        do_reset();
        ireq = 1'b1; iaddr = 12'h050;
        dreq = 1'b1; daddr = 12'h040; dwe = 1'b0;
        #1;
        n_tests++; if (dgnt !== 1'b1) begin n_fail++; $display("FAIL mrst_load_gnt dgnt=%b required 1", dgnt); end
        cyc();
        ireq = 1'b0;
        n_tests++; if (drvalid !== 1'b1 || conflicts !== 16'd1) begin
            n_fail++; $display("FAIL mrst_pre drv=%b conf=%0d required 1/1", drvalid, conflicts);
        end
        dwe = 1'b1; daddr = 12'h041; dwdata = 32'h1234_5678;
        #1;
        n_tests++; if (mwe !== 1'b1) begin n_fail++; $display("FAIL mrst_store_pending mwe=%b required 1", mwe); end
        rst_n = 1'b0;
        #1;
        n_tests++; if (drvalid !== 1'b0 || conflicts !== 16'd0 || mwe !== 1'b0 || dgnt !== 1'b0) begin
            n_fail++; $display("FAIL mrst_async drv=%b conf=%0d mwe=%b dgnt=%b required 0/0/0/0", drvalid, conflicts, mwe, dgnt);
        end
        cyc();
        rst_n = 1'b1; dwe = 1'b0;
        #1;
        cyc();
        dreq = 1'b0;
        n_tests++; if (drvalid !== 1'b1 || drdata !== 32'hA000_0041) begin
            n_fail++; $display("FAIL mrst_mem_unchanged drv=%b data=%h required 1/a0000041", drvalid, drdata);
        end
        cyc();
    endtask

    initial begin
        rst_n = 1'b0; ce = 1'b1;
        ireq = 1'b0; iaddr = 12'd0;
        dreq = 1'b0; daddr = 12'd0; dwe = 1'b0; dwdata = 32'd0;
        test_reset();
        test_i_only();
        test_store_load();
        test_starvation();
        test_ce_gating();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/m_mem_arbiter.md
# m_mem_arbiter

Two-port arbiter that shares one synchronous single-port 4K-word memory (`m_memory`: 12-bit word address, 1-cycle registered read) between the instruction-fetch port (I) and the load/store port (D) of a multicycle processor. It grants at most one access per cycle and tags each returning read to its owner. Its policy is D-priority with a starvation guard for I. It sits between `m_proc`'s fetch/execute logic and a single shared `m_memory` instance.

## Interface
- P_MAXD, default 4: max consecutive D grants while I is pending before I is forced through (legal range 1..15).
- w_clk  input  1  clock; all state updates on rising edge.
- w_rst_n  input  1  reset, asynchronous, active-low.
- w_ce  input  1  clock enable; when low, no new grants are issued.
- w_ireq  input  1  I-port read request; held until w_ignt.
- w_iaddr  input  12  I-port word address.
- w_ignt  output  1  I request accepted this cycle (combinational).
- w_irvalid  output  1  I read data valid (registered).
- w_irdata  output  32  I read data.
- w_dreq  input  1  D-port request; held, with addr/we/wdata stable, until w_dgnt.
- w_daddr  input  12  D-port word address.
- w_dwe  input  1  1 = store, 0 = load.
- w_dwdata  input  32  store data.
- w_dgnt  output  1  D request accepted this cycle (combinational).
- w_drvalid  output  1  D load data valid (registered).
- w_drdata  output  32  D load data.
- w_maddr  output  12  memory address.
- w_mwe  output  1  memory write enable.
- w_mdin  output  32  memory write data.
- w_mdout  input  32  memory registered read data.
- w_conflicts  output  16  saturating count of cycles with both requests pending and w_ce high.

## Operation
- Grant decision is made each cycle when w_rst_n and w_ce are both high:
  - Only one request pending: that port wins.
  - Both pending and r_dcnt < P_MAXD: D wins.
  - Both pending and r_dcnt == P_MAXD: I wins.
- At most one of w_ignt/w_dgnt is high. Both are 0 while reset is asserted or w_ce is low.
- r_dcnt, 4-bit:
  - Increments on a D grant while w_ireq is high.
  - Clears on any I grant, or on any cycle where w_ireq is low.
  - Never exceeds P_MAXD.
- Memory drive:
  - w_maddr = winner's address. With no grant it holds the last granted address.
  - w_mwe = w_dgnt & w_dwe, so it is 0 with no grant.
  - w_mdin = w_dwdata at all times.
- Owner tag (registered, next cycle):
  - w_irvalid <= w_ignt.
  - w_drvalid <= w_dgnt & ~w_dwe. Stores never produce rvalid.
- w_irdata and w_drdata both pass w_mdout through. They are meaningful only while the matching rvalid is high.
- w_conflicts increments when w_ireq & w_dreq & w_ce, and saturates at 16'hFFFF.
- Read-after-write to the same address in consecutive grants returns the new data, because the memory write lands at the grant edge.

## Timing
- Reset state: w_irvalid=0, w_drvalid=0, r_dcnt=0, w_conflicts=0, last address=0. Effective immediately on w_rst_n low, asynchronously.
- Read latency is 1 cycle. Grant in cycle N -> rvalid high in cycle N+1 only, with data = mem[addr] at the edge ending N.
- Back-to-back grants are allowed every cycle. A port can receive a grant in N+1 while its rvalid from N is high.
- Store completes at the edge ending its grant cycle. The requester may drop or change w_dreq in the next cycle.
- w_ce low in cycle N: no grant. The rvalid for a grant made in N-1 is still delivered in N. r_dcnt holds.
- Reset mid-operation: an in-flight rvalid is squashed, and a pending store with a grant not yet clocked is not written (w_mwe forced 0).
- Request dropped before grant is a protocol violation. Behaviour is unspecified but must not produce rvalid for that port.

## Test plan
- Reset: hold w_rst_n=0 with both requests high -> w_ignt=w_dgnt=0, w_mwe=0, all registered outputs 0. Release -> D granted on the first cycle.
- I only: w_ireq=1 with iaddr=0,1,2 in consecutive cycles -> w_ignt=1 each cycle, and w_irvalid=1 one cycle later with mem[0], mem[1], mem[2] in order.
- D store then load: store 32'hDEADBEEF to 12'h100, then load 12'h100 -> w_mwe=1 only in the store grant cycle. In the load cycle+1, w_drvalid=1 and w_drdata=32'hDEADBEEF, with no w_drvalid after the store.
- Starvation with P_MAXD=4: both requesting continuously -> grant pattern D,D,D,D,I repeating. w_conflicts increments every cycle.
- w_ce gating: w_ce drops for 3 cycles right after an I read grant -> the rvalid for that grant is still delivered, there are no grants for those 3 cycles, and the previous sequence resumes once w_ce returns.
- Mid-operation reset: assert w_rst_n=0 in the cycle after a load grant -> w_drvalid immediately 0 and w_conflicts=0. A store whose grant had not been clocked leaves memory unchanged.
